// File: rtl/r4booth_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : r4booth_seq_multiplier
//  Purpose  : Iterative radix-4 modified-Booth multiplier, one digit per cycle,
//             valid/ready on operand and result sides.
//  Options  : R4BOOTH_EARLY_TERM_EN - finish as soon as remaining digits are 0
//  Revision : 1.0 - initial release
// ============================================================================
module r4booth_seq_multiplier #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              a_signed_i,
  input  logic              b_signed_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [2*XLEN-1:0] product_o,
  output logic              busy_o
);

  localparam int NDIG = XLEN / 2 + 1;
  localparam int PW   = 2 * XLEN;
  localparam int MW   = XLEN + 2;
  localparam int CW   = $clog2(NDIG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_mcand;
  logic [MW-1:0]   r_mq;
  logic            r_prev;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_product;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic [2:0]      w_pat;
  logic            w_mul1x;
  logic            w_mul2x;
  logic            w_sign;
  logic [PW-1:0]   w_mag;
  logic [PW-1:0]   w_addend;
  logic [PW-1:0]   w_acc_next;
  logic [MW-1:0]   w_mq_next;
  logic            w_prev_next;
  logic            w_last;

  // Booth recoding of the current bit-pair window
  assign w_pat      = {r_mq[1:0], r_prev};
  assign w_mul1x    = w_pat[1] ^ w_pat[0];
  assign w_mul2x    = (w_pat == 3'b011) || (w_pat == 3'b100);
  assign w_sign     = w_pat[2];
  assign w_mag      = w_mul1x ? r_mcand :
                      w_mul2x ? {r_mcand[PW-2:0], 1'b0} : '0;
  assign w_addend   = w_sign ? (~w_mag + {{(PW-1){1'b0}}, 1'b1}) : w_mag;
  assign w_acc_next = r_acc + w_addend;

  assign w_mq_next   = {{2{r_mq[MW-1]}}, r_mq[MW-1:2]};
  assign w_prev_next = r_mq[1];

`ifdef R4BOOTH_EARLY_TERM_EN
  // Once the remaining window is pure sign extension every later digit is 0
  logic w_rest_zero;
  assign w_rest_zero = ((w_mq_next == '0) && !w_prev_next) ||
                       ((&w_mq_next) && w_prev_next);
  assign w_last = (r_cnt == CW'(NDIG - 1)) || w_rest_zero;
`else
  assign w_last = (r_cnt == CW'(NDIG - 1));
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mq        <= '0;
      r_prev      <= 1'b0;
      r_cnt       <= '0;
      r_product   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_mcand    <= {{XLEN{a_signed_i & a_i[XLEN-1]}}, a_i};
            r_mq       <= {{2{b_signed_i & b_i[XLEN-1]}}, b_i};
            r_prev     <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= S_BUSY;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_BUSY: begin
          r_acc   <= w_acc_next;
          r_mcand <= {r_mcand[PW-3:0], 2'b00};
          r_mq    <= w_mq_next;
          r_prev  <= w_prev_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            // Result is captured separately so partial sums never reach the port
            r_product   <= w_acc_next;
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign busy_o      = r_busy;
  assign product_o   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_r4booth_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_r4booth_seq_multiplier
//  Purpose  : Directed self-checking bench for r4booth_seq_multiplier (XLEN=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_r4booth_seq_multiplier;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        a_signed_i;
  logic        b_signed_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] product_o;
  logic        busy_o;

  int tests_run    = 0;
  int tests_failed = 0;

  r4booth_seq_multiplier #(.XLEN(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .a_signed_i  (a_signed_i),
    .b_signed_i  (b_signed_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .product_o   (product_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Present operands for one accept edge, then scramble them and count edges
  // until out_valid_o (bounded at 40 edges).
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b,
                                input logic as, input logic bs,
                                output logic [63:0] p, output int lat);
    @(negedge clk_i);
    a_i = a; b_i = b; a_signed_i = as; b_signed_i = bs; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    a_i = 32'hDEAD_BEEF; b_i = 32'h1234_5678; a_signed_i = ~as; b_signed_i = ~bs;
    lat = 0;
    while (!out_valid_o && lat < 40) begin
      @(posedge clk_i); #1;
      lat++;
    end
    p = product_o;
  endtask

  task automatic release_result();
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    tests_run++; if (in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_o); end
    tests_run++; if (out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); end
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    tests_run++; if (product_o !== 64'h0) begin tests_failed++; $display("FAIL reset_product: got %h expected 0", product_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_unsigned_small();
    logic [63:0] p; int lat; int exp_lat;
`ifdef R4BOOTH_EARLY_TERM_EN
    exp_lat = 3;
`else
    exp_lat = 17;
`endif
    start_and_wait(32'd7, 32'd9, 1'b0, 1'b0, p, lat);
    tests_run++; if (p !== 64'h3F) begin tests_failed++; $display("FAIL mul_7x9: got %h expected %h", p, 64'h3F); end
    tests_run++; if (lat !== exp_lat) begin tests_failed++; $display("FAIL lat_7x9: got %0d expected %0d", lat, exp_lat); end
    tests_run++; if (in_ready_o !== 1'b0) begin tests_failed++; $display("FAIL done_in_ready: got %b expected 0", in_ready_o); end
    release_result();
    tests_run++; if (in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL idle_in_ready: got %b expected 1", in_ready_o); end
  endtask

  task automatic test_signed_mix();
    logic [63:0] p; int lat;
    start_and_wait(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, p, lat);
    tests_run++; if (p !== 64'h0000000000000001) begin tests_failed++; $display("FAIL ss_m1xm1: got %h expected 0000000000000001", p); end
    release_result();
    start_and_wait(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, p, lat);
    tests_run++; if (p !== 64'hFFFFFFFE00000002) begin tests_failed++; $display("FAIL su_m2xmax: got %h expected FFFFFFFE00000002", p); end
    release_result();
    start_and_wait(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, p, lat);
    tests_run++; if (p !== 64'hFFFFFFFE00000001) begin tests_failed++; $display("FAIL uu_maxxmax: got %h expected FFFFFFFE00000001", p); end
    release_result();
    start_and_wait(32'h80000000, 32'h80000000, 1'b1, 1'b1, p, lat);
    tests_run++; if (p !== 64'h4000000000000000) begin tests_failed++; $display("FAIL ss_minxmin: got %h expected 4000000000000000", p); end
    release_result();
    start_and_wait(32'h80000000, 32'h00000002, 1'b0, 1'b0, p, lat);
    tests_run++; if (p !== 64'h0000000100000000) begin tests_failed++; $display("FAIL uu_msbx2: got %h expected 0000000100000000", p); end
    release_result();
  endtask

  task automatic test_backpressure();
    logic [63:0] p; int lat;
    start_and_wait(32'd100, 32'd200, 1'b0, 1'b0, p, lat);
    tests_run++; if (p !== 64'h4E20) begin tests_failed++; $display("FAIL bp_product: got %h expected 4e20", p); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      in_valid_i = (i % 2 == 0); a_i = 32'd3 + i; b_i = 32'd11;
      @(posedge clk_i); #1;
      tests_run++; if (product_o !== 64'h4E20 || out_valid_o !== 1'b1 || in_ready_o !== 1'b0)
        begin tests_failed++; $display("FAIL bp_hold%0d: got p=%h v=%b r=%b expected p=4e20 v=1 r=0", i, product_o, out_valid_o, in_ready_o); end
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    tests_run++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL bp_release: got v=%b r=%b expected v=0 r=1", out_valid_o, in_ready_o); end
    tests_run++; if (product_o !== 64'h4E20) begin tests_failed++; $display("FAIL bp_keep: got %h expected 4e20", product_o); end
    @(posedge clk_i); #1;
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL bp_no_accept: got busy=%b expected 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] p; int lat; int exp_lat;
`ifdef R4BOOTH_EARLY_TERM_EN
    exp_lat = 3;
`else
    exp_lat = 17;
`endif
    start_and_wait(32'd2, 32'd3, 1'b0, 1'b0, p, lat);
    tests_run++; if (p !== 64'h6) begin tests_failed++; $display("FAIL b2b_first: got %h expected 6", p); end
    @(negedge clk_i);
    out_ready_i = 1'b1; in_valid_i = 1'b1; a_i = 32'd11; b_i = 32'd13; a_signed_i = 1'b0; b_signed_i = 1'b0;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    tests_run++; if (busy_o !== 1'b0 || in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_no_same_cycle: got busy=%b r=%b expected busy=0 r=1", busy_o, in_ready_o); end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept: got busy=%b expected 1", busy_o); end
    lat = 0;
    while (!out_valid_o && lat < 40) begin @(posedge clk_i); #1; lat++; end
    tests_run++; if (product_o !== 64'h8F) begin tests_failed++; $display("FAIL b2b_second: got %h expected 8f", product_o); end
    tests_run++; if (lat !== 13 - 13 + exp_lat) begin tests_failed++; $display("FAIL b2b_lat: got %0d expected %0d", lat, exp_lat); end
    release_result();
  endtask

  task automatic test_reset_mid();
    logic [63:0] p; int lat;
    @(negedge clk_i);
    a_i = 32'h12345678; b_i = 32'hA5A5A5A5; a_signed_i = 1'b0; b_signed_i = 1'b0; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (8) @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    tests_run++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0 || product_o !== 64'h0)
      begin tests_failed++; $display("FAIL mid_reset: got r=%b v=%b busy=%b p=%h expected r=1 v=0 busy=0 p=0", in_ready_o, out_valid_o, busy_o, product_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    start_and_wait(32'd3, 32'd5, 1'b0, 1'b0, p, lat);
    tests_run++; if (p !== 64'h0F) begin tests_failed++; $display("FAIL after_reset_3x5: got %h expected f", p); end
    release_result();
  endtask

  task automatic test_early_term();
    logic [63:0] p; int lat; int l1; int l2;
`ifdef R4BOOTH_EARLY_TERM_EN
    l1 = 1; l2 = 2;
`else
    l1 = 17; l2 = 17;
`endif
    start_and_wait(32'd123, 32'd3, 1'b0, 1'b0, p, lat);
    tests_run++; if (p !== 64'h171) begin tests_failed++; $display("FAIL et_123x3: got %h expected 171", p); end
    tests_run++; if (lat !== l2) begin tests_failed++; $display("FAIL et_123x3_lat: got %0d expected %0d", lat, l2); end
    release_result();
    start_and_wait(32'd77, 32'd0, 1'b0, 1'b0, p, lat);
    tests_run++; if (p !== 64'h0) begin tests_failed++; $display("FAIL et_bzero: got %h expected 0", p); end
    tests_run++; if (lat !== l1) begin tests_failed++; $display("FAIL et_bzero_lat: got %0d expected %0d", lat, l1); end
    release_result();
    start_and_wait(32'd5, 32'hFFFFFFFF, 1'b1, 1'b1, p, lat);
    tests_run++; if (p !== 64'hFFFFFFFFFFFFFFFB) begin tests_failed++; $display("FAIL et_5xm1: got %h expected fffffffffffffffb", p); end
    tests_run++; if (lat !== l1) begin tests_failed++; $display("FAIL et_5xm1_lat: got %0d expected %0d", lat, l1); end
    release_result();
  endtask

  initial begin
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    a_i = '0; b_i = '0; a_signed_i = 1'b0; b_signed_i = 1'b0;
    test_reset();
    test_unsigned_small();
    test_signed_mix();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_early_term();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/r4booth_seq_multiplier.md
Name: r4booth_seq_multiplier

Overview:
- Iterative radix-4 modified-Booth multiplier sequencer for the RISC-V M-extension datapath.
- Each busy cycle recodes one bit-pair window of the multiplier into {mul1x, mul2x, mulsign} controls using the team's standard Booth table.
- Selects 0/±1x/±2x of the multiplicand and accumulates it into a 2*XLEN product register.
- Valid/ready handshakes on the operand and result sides decouple it from the issue stage and the writeback stage.

Parameters:
XLEN, 32, operand width in bits; must be even and at least 4
NDIG, XLEN/2+1, number of Booth digits; derived localparam, not overridable

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
in_valid_i  input  1  operand request valid
in_ready_o  output  1  block can accept operands
a_i  input  XLEN  multiplicand
b_i  input  XLEN  multiplier
a_signed_i  input  1  1 = a_i is two's complement, 0 = unsigned
b_signed_i  input  1  1 = b_i is two's complement, 0 = unsigned
out_valid_o  output  1  product valid
out_ready_i  input  1  consumer accepts product
product_o  output  2*XLEN  full product, modulo 2^(2*XLEN)
busy_o  output  1  high while in state BUSY

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni; it clears all state immediately, independent of clk_i.
- Reset values:
  - state = IDLE, in_ready_o = 1, out_valid_o = 0, busy_o = 0, product_o = 0.
  - Internal accumulator, multiplicand, multiplier, digit counter and prev bit = 0.
- States:
  - IDLE: in_ready_o = 1. On in_valid_i && in_ready_o, latch operands and go to BUSY.
  - BUSY: one digit per rising edge. After the digit with counter = NDIG-1 (or early termination), go to DONE.
  - DONE: out_valid_o = 1. On out_ready_i, go to IDLE.
- in_ready_o is high only in IDLE. There is no accept in the same cycle as a result handshake.
- Latch on accept:
  - mcand = a_i extended to 2*XLEN (sign-extended if a_signed_i, else zero-extended).
  - mq = b_i extended to XLEN+2 bits (sign- or zero-extended per b_signed_i).
  - prev = 0, acc = 0, cnt = 0.
- Per BUSY edge:
  - Window pattern = {mq[1], mq[0], prev}.
  - mul1x = mq[1]^... no: mul1x = pattern[1]^pattern[0]; mul2x = (pattern==011 || pattern==100); sign = pattern[2].
  - mag = mul1x ? mcand : mul2x ? mcand<<1 : 0.
  - acc <= acc + (sign ? -mag : mag), mod 2^(2*XLEN). Pattern 111 yields -0 = 0.
  - Then mcand <<= 2, prev <= mq[1], mq <= arithmetic shift right by 2, cnt <= cnt + 1.
- Latency: out_valid_o rises exactly NDIG rising edges after the accept edge (17 for XLEN=32).
- Output hold: product_o = acc, valid only while out_valid_o. It stays stable in DONE until the handshake, for any length of backpressure.
- After the result handshake, product_o keeps its last value; it is not cleared.
- Inputs ignored: in_valid_i while not IDLE; out_ready_i while not DONE.
- Reset mid-operation: any rst_ni low aborts the operation and returns to the reset values. No partial result is ever presented.
- Operand changes on a_i/b_i after the accept edge have no effect.

Optional Feature:
- Macro: R4BOOTH_EARLY_TERM_EN.
- Defined: on each BUSY edge, after the shift, if (new mq all 0 and new prev = 0) or (new mq all 1 and new prev = 1), all remaining digits are 0.
  - The block goes to DONE immediately, with acc already final.
  - Minimum latency is 1 cycle, maximum NDIG.
- Not defined: fixed NDIG-cycle latency; no termination-detect logic is synthesized.

Test Plan:
- XLEN=32, unsigned 7*9 -> product_o = 0x000000000000003F; out_valid_o rises 17 edges after accept (macro off).
- Signed -1 * signed -1 (a=b=0xFFFFFFFF, both signed) -> 0x0000000000000001.
- Signed a=0xFFFFFFFE × unsigned b=0xFFFFFFFF -> 0xFFFFFFFE00000002. Unsigned 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE00000001.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE.
  - product_o stable, out_valid_o=1, in_ready_o=0.
  - in_valid_i pulses are ignored.
  - Returns to IDLE one edge after out_ready_i=1.
- Reset mid-operation: assert rst_ni low at digit 8 without a clock edge.
  - Outputs go to reset values immediately.
  - A next operation 3*5 returns 0x0F correctly.
- With R4BOOTH_EARLY_TERM_EN: unsigned 123*3 -> 0x171 with out_valid_o 2 edges after accept; b=0 -> 0 after 1 edge; signed a=5, b=-1 -> 0xFFFFFFFFFFFFFFFB after 1 edge.
